// File: rtl/riscv_pkg.sv
// Architectural widths of the observed RISC-V core.
package riscv;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 39;
endpackage

// File: rtl/rvfi_monitor_pkg.sv
// Shared types and helpers for the RVFI commit monitor.
package rvfi_monitor_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        TIMEOUT = 2'd2
    } mon_state_e;

    localparam logic [riscv::XLEN-1:0] CAUSE_INSN_MISALIGNED  = 'd0;
    localparam logic [riscv::XLEN-1:0] CAUSE_INSN_ACCESS      = 'd1;
    localparam logic [riscv::XLEN-1:0] CAUSE_ILLEGAL_INSN     = 'd2;
    localparam logic [riscv::XLEN-1:0] CAUSE_BREAKPOINT       = 'd3;
    localparam logic [riscv::XLEN-1:0] CAUSE_LD_MISALIGNED    = 'd4;
    localparam logic [riscv::XLEN-1:0] CAUSE_LD_ACCESS        = 'd5;
    localparam logic [riscv::XLEN-1:0] CAUSE_ST_MISALIGNED    = 'd6;
    localparam logic [riscv::XLEN-1:0] CAUSE_ST_ACCESS        = 'd7;

    typedef struct packed {
        logic [7:0]               hart_id;
        logic [1:0]               port;
        logic [63:0]              pc;
        logic [31:0]              insn;
        logic [1:0]               mode;
        logic                     trap;
        logic [riscv::XLEN-1:0]   cause;
        logic [4:0]               rd_addr;
        logic [riscv::XLEN-1:0]   rd_wdata;
        logic [riscv::XLEN-1:0]   mem_addr;
        logic [riscv::XLEN-1:0]   mem_wdata;
        logic [riscv::XLEN/8-1:0] mem_wmask;
    } trace_rec_t;

    function automatic logic [63:0] sext_pc(input logic [riscv::XLEN-1:0] pc);
        return {{(64 - riscv::VLEN){pc[riscv::VLEN-1]}}, pc[riscv::VLEN-1:0]};
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [2:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction
endpackage

// File: rtl/rvfi_pkg.sv
// One RVFI commit port as presented by the core.
package rvfi_pkg;
    typedef struct packed {
        logic                     valid;
        logic                     trap;
        logic [31:0]              insn;
        logic [1:0]               mode;
        logic [riscv::XLEN-1:0]   cause;
        logic [4:0]               rd_addr;
        logic [riscv::XLEN-1:0]   rd_wdata;
        logic [riscv::XLEN-1:0]   pc_rdata;
        logic [riscv::XLEN-1:0]   mem_addr;
        logic [riscv::XLEN-1:0]   mem_wdata;
        logic [riscv::XLEN/8-1:0] mem_wmask;
    } rvfi_instr_t;
endpackage

// File: rtl/rvfi_mw_fifo.sv
// Multi-write, single-read record buffer; set bits of wr_mask are packed into
// consecutive slots in ascending index order. The caller guarantees the batch fits.
module rvfi_mw_fifo #(
    parameter int unsigned NR_WRITE = 2,
    parameter int unsigned DEPTH    = 8,
    parameter type         T        = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NR_WRITE-1:0]      wr_mask,
    input  T                         wr_data [NR_WRITE],
    output logic [$clog2(DEPTH):0]   free,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output T                         rd_data
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MEM_N = 1 << PTR_W;

    T                 mem [MEM_N];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, n_wr;
    logic [PTR_W-1:0] slot [NR_WRITE];
    logic             pop;

    always_comb begin
        n_wr = '0;
        for (int i = 0; i < NR_WRITE; i++) begin
            slot[i] = wr_ptr + n_wr[PTR_W-1:0];
            n_wr    = n_wr + CNT_W'(wr_mask[i]);
        end
    end

    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign free     = CNT_W'(DEPTH) - count;
    // Empty buffer presents an all-zero record rather than stale memory.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_wr[PTR_W-1:0];
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + n_wr - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_WRITE; i++) begin
            if (wr_mask[i]) mem[slot[i]] <= wr_data[i];
        end
    end
endmodule

// File: rtl/rvfi_commit_monitor.sv
// Turns RVFI commits/traps into buffered trace records and keeps run statistics
// until the program writes tohost or the cycle limit expires.
module rvfi_commit_monitor
    import rvfi_monitor_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter logic [7:0]  HART_ID         = 8'h0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  rvfi_pkg::rvfi_instr_t  rvfi_i [NR_COMMIT_PORTS],
    input  logic [riscv::XLEN-1:0] tohost_addr_i,
    input  logic [31:0]            timeout_i,
    output logic                   rec_valid_o,
    input  logic                   rec_ready_i,
    output trace_rec_t             rec_o,
    output mon_state_e             state_o,
    output logic [riscv::XLEN-1:0] exit_code_o,
    output logic [63:0]            exit_pc_o,
    output logic [63:0]            instret_o,
    output logic [31:0]            trap_cnt_o,
    output logic [31:0]            drop_cnt_o,
    output logic [31:0]            cycles_o
);
    // state   | meaning
    // RUN     | commits recorded, counters advancing
    // DONE    | tohost written; frozen, buffer still drains
    // TIMEOUT | cycle limit reached; frozen, buffer still drains
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    mon_state_e                 state, state_nxt;
    logic [NR_COMMIT_PORTS-1:0] hit, keep, push_mask, fifo_mask;
    logic                       blocked, any_hit, limit, active, accept;
    logic [2:0]                 n_ev, n_valid, n_trap;
    logic [riscv::XLEN-1:0]     win_code;
    logic [63:0]                win_pc;
    logic [CNT_W-1:0]           free;
    trace_rec_t                 recs [NR_COMMIT_PORTS];

    always_comb begin
        hit       = '0;
        keep      = '0;
        push_mask = '0;
        blocked   = 1'b0;
        win_code  = '0;
        win_pc    = '0;
        n_ev      = '0;
        n_valid   = '0;
        n_trap    = '0;
        // Ports above the first tohost store never happened as far as the trace is concerned.
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            hit[i]  = rvfi_i[i].valid && (|rvfi_i[i].mem_wmask) && (tohost_addr_i != '0)
                      && (rvfi_i[i].mem_addr == tohost_addr_i) && (rvfi_i[i].mem_wdata != '0);
            keep[i] = !blocked;
            if (hit[i] && !blocked) begin
                win_code = rvfi_i[i].mem_wdata;
                win_pc   = sext_pc(rvfi_i[i].pc_rdata);
            end
            blocked = blocked | hit[i];
        end
        any_hit = blocked;
        limit   = (timeout_i != '0) && (cycles_o == timeout_i) && !any_hit;
        active  = (state == RUN) && !limit;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            push_mask[i] = active && keep[i] && (rvfi_i[i].valid || rvfi_i[i].trap);
            n_ev    = n_ev + 3'(push_mask[i]);
            n_valid = n_valid + 3'(keep[i] && rvfi_i[i].valid);
            n_trap  = n_trap + 3'(keep[i] && rvfi_i[i].trap && !rvfi_i[i].valid);
        end
        accept    = 32'(n_ev) <= 32'(free);
        fifo_mask = accept ? push_mask : '0;
    end

    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            recs[i] = '{hart_id:   HART_ID,
                        port:      2'(i),
                        pc:        sext_pc(rvfi_i[i].pc_rdata),
                        insn:      rvfi_i[i].insn,
                        mode:      rvfi_i[i].mode,
                        trap:      rvfi_i[i].trap && !rvfi_i[i].valid,
                        cause:     rvfi_i[i].cause,
                        rd_addr:   rvfi_i[i].rd_addr,
                        rd_wdata:  rvfi_i[i].rd_wdata,
                        mem_addr:  rvfi_i[i].mem_addr,
                        mem_wdata: rvfi_i[i].mem_wdata,
                        mem_wmask: rvfi_i[i].mem_wmask};
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN) begin
            if (any_hit)    state_nxt = DONE;
            else if (limit) state_nxt = TIMEOUT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= RUN;
            instret_o   <= '0;
            trap_cnt_o  <= '0;
            drop_cnt_o  <= '0;
            cycles_o    <= '0;
            exit_code_o <= '0;
            exit_pc_o   <= '0;
        end else begin
            state <= state_nxt;
            if (active) begin
                instret_o  <= instret_o + 64'(n_valid);
                trap_cnt_o <= sat_add32(trap_cnt_o, n_trap);
                cycles_o   <= cycles_o + 32'd1;
                if (!accept) drop_cnt_o <= sat_add32(drop_cnt_o, n_ev);
                if (any_hit) begin
                    exit_code_o <= win_code;
                    exit_pc_o   <= win_pc;
                end
            end
        end
    end

    assign state_o = state;

    rvfi_mw_fifo #(
        .NR_WRITE (NR_COMMIT_PORTS),
        .DEPTH    (FIFO_DEPTH),
        .T        (trace_rec_t)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .wr_mask  (fifo_mask),
        .wr_data  (recs),
        .free     (free),
        .rd_valid (rec_valid_o),
        .rd_ready (rec_ready_i),
        .rd_data  (rec_o)
    );
endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// Randomized scoreboard bench for rvfi_commit_monitor with a behavioural model.
module tb_rvfi_commit_monitor;
    import rvfi_pkg::*;
    import rvfi_monitor_pkg::*;

    localparam int          NR     = 2;
    localparam int          DEPTH  = 8;
    localparam logic [7:0]  HART   = 8'hA5;
    localparam logic [63:0] TOHOST = 64'h8000_1000;

    logic        clk = 1'b0;
    logic        rst;
    rvfi_instr_t drv [NR];
    logic [63:0] tohost;
    logic [31:0] timeout;
    logic        rec_ready;
    logic        rec_valid;
    trace_rec_t  rec;
    mon_state_e  state;
    logic [63:0] exit_code, exit_pc, instret;
    logic [31:0] trap_cnt, drop_cnt, cycles;

    rvfi_commit_monitor #(.NR_COMMIT_PORTS(NR), .FIFO_DEPTH(DEPTH), .HART_ID(HART)) dut (
        .clk_i(clk), .rst_i(rst), .rvfi_i(drv), .tohost_addr_i(tohost), .timeout_i(timeout),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready), .rec_o(rec), .state_o(state),
        .exit_code_o(exit_code), .exit_pc_o(exit_pc), .instret_o(instret),
        .trap_cnt_o(trap_cnt), .drop_cnt_o(drop_cnt), .cycles_o(cycles)
    );

    initial forever #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    trace_rec_t  exp_q [$];
    mon_state_e  m_state;
    int          m_occ;
    logic [63:0] m_instret, m_exit_code, m_exit_pc;
    logic [31:0] m_trap, m_drop, m_cycles;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input trace_rec_t act, input trace_rec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input logic [31:0] a, input int n);
        longint s;
        s = longint'(a) + longint'(n);
        if (s > longint'(32'hFFFF_FFFF)) return 32'hFFFF_FFFF;
        return 32'(s);
    endfunction

    function automatic logic [63:0] tb_sext(input logic [63:0] pc);
        logic [63:0] lo;
        lo = pc & ((64'd1 << riscv::VLEN) - 64'd1);
        return pc[riscv::VLEN-1] ? lo - (64'd1 << riscv::VLEN) : lo;
    endfunction

    function automatic trace_rec_t exp_rec(input int port, input rvfi_instr_t r);
        trace_rec_t e;
        e.hart_id   = HART;
        e.port      = 2'(port);
        e.pc        = tb_sext(r.pc_rdata);
        e.insn      = r.insn;
        e.mode      = r.mode;
        e.trap      = r.trap && !r.valid;
        e.cause     = r.cause;
        e.rd_addr   = r.rd_addr;
        e.rd_wdata  = r.rd_wdata;
        e.mem_addr  = r.mem_addr;
        e.mem_wdata = r.mem_wdata;
        e.mem_wmask = r.mem_wmask;
        return e;
    endfunction

    function automatic rvfi_instr_t rnd_instr(input int p_valid, input int p_trap);
        rvfi_instr_t r;
        r.valid     = ($urandom_range(99) < p_valid);
        r.trap      = ($urandom_range(99) < p_trap);
        r.insn      = $urandom;
        r.mode      = 2'($urandom_range(3));
        r.cause     = 64'($urandom_range(7));
        r.rd_addr   = 5'($urandom_range(31));
        r.rd_wdata  = {$urandom, $urandom};
        r.pc_rdata  = {$urandom, $urandom};
        r.mem_addr  = {$urandom, $urandom};
        r.mem_wdata = {$urandom, $urandom};
        r.mem_wmask = 8'($urandom_range(255));
        return r;
    endfunction

    function automatic bit is_tohost(input rvfi_instr_t r);
        return r.valid && r.mem_wmask != 0 && tohost != 0 && r.mem_addr == tohost && r.mem_wdata != 0;
    endfunction

    task automatic model_reset();
        m_state = RUN; m_occ = 0; m_instret = 0; m_exit_code = 0; m_exit_pc = 0;
        m_trap = 0; m_drop = 0; m_cycles = 0;
        exp_q.delete();
    endtask

    // Effect of the currently driven inputs at the coming clock edge.
    task automatic model_cycle();
        int         hit_idx, last, pushed, pop, nv, nt;
        trace_rec_t batch [$];
        pop = (m_occ > 0 && rec_ready) ? 1 : 0;
        pushed = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_state == RUN) begin
            hit_idx = -1;
            for (int i = 0; i < NR; i++)
                if (hit_idx < 0 && is_tohost(drv[i])) hit_idx = i;
            if (hit_idx < 0 && timeout != 0 && m_cycles == timeout) begin
                m_state = TIMEOUT;
            end else begin
                last = (hit_idx < 0) ? NR - 1 : hit_idx;
                nv = 0; nt = 0;
                for (int i = 0; i <= last; i++) begin
                    if (drv[i].valid) nv++;
                    else if (drv[i].trap) nt++;
                    if (drv[i].valid || drv[i].trap) batch.push_back(exp_rec(i, drv[i]));
                end
                if (batch.size() <= DEPTH - m_occ) begin
                    foreach (batch[k]) exp_q.push_back(batch[k]);
                    pushed = batch.size();
                end else begin
                    m_drop = sat32(m_drop, batch.size());
                end
                m_instret = m_instret + 64'(nv);
                m_trap    = sat32(m_trap, nt);
                m_cycles  = m_cycles + 1;
                if (hit_idx >= 0) begin
                    m_state     = DONE;
                    m_exit_code = drv[hit_idx].mem_wdata;
                    m_exit_pc   = tb_sext(drv[hit_idx].pc_rdata);
                end
            end
        end
        m_occ = m_occ - pop + pushed;
    endtask

    task automatic check_status();
        chk("state", 64'(state), 64'(m_state));
        chk("rec_valid", 64'(rec_valid), 64'(m_occ != 0));
        chk("instret", instret, m_instret);
        chk("trap_cnt", 64'(trap_cnt), 64'(m_trap));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("cycles", 64'(cycles), 64'(m_cycles));
        chk("exit_code", exit_code, m_exit_code);
        chk("exit_pc", exit_pc, m_exit_pc);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #2;
        check_status();
    endtask

    task automatic idle_all();
        for (int i = 0; i < NR; i++) drv[i] = '0;
    endtask

    task automatic rand_all(input int p_valid, input int p_trap);
        for (int i = 0; i < NR; i++) drv[i] = rnd_instr(p_valid, p_trap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_all(80, 20);
        step();
        rst = 1'b0;
        idle_all();
    endtask

    task automatic drain();
        idle_all();
        rec_ready = 1'b1;
        repeat (DEPTH + 2) step();
    endtask

    // Scoreboard side: every accepted handshake must match the oldest expected record.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rec_extra: got %h expected none", rec);
                end else begin
                    chk_rec("rec_stream", rec, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        trace_rec_t zero_rec;
        zero_rec  = '0;
        rst       = 1'b1;
        tohost    = '0;
        timeout   = '0;
        rec_ready = 1'b0;
        idle_all();
        model_reset();
        step();
        step();
        chk_rec("reset_rec_o", rec, zero_rec);
        rst = 1'b0;

        // Two valid ports for three cycles, sink always ready.
        rec_ready = 1'b1;
        repeat (3) begin rand_all(100, 0); step(); end
        idle_all();
        repeat (6) step();
        chk("two_port_instret", instret, 64'd6);
        chk("two_port_drop", 64'(drop_cnt), 64'd0);

        // Blocked sink: four batches fill the buffer, the fifth is dropped whole.
        rec_ready = 1'b0;
        repeat (5) begin rand_all(100, 0); step(); end
        chk("full_drop_cnt", 64'(drop_cnt), 64'd2);
        chk("full_rec_valid", 64'(rec_valid), 64'd1);
        chk_rec("full_head_held", rec, exp_q[0]);
        idle_all();
        repeat (3) step();
        chk_rec("full_head_stable", rec, exp_q[0]);
        drain();

        // Trap-only event on port 0.
        drv[0] = rnd_instr(0, 0);
        drv[0].trap  = 1'b1;
        drv[0].cause = CAUSE_ILLEGAL_INSN;
        drv[1] = '0;
        step();
        chk("trap_only_cnt", 64'(trap_cnt), 64'd1);
        chk("trap_only_instret", instret, 64'd16);
        drain();

        // Random traffic with a stalling sink.
        repeat (400) begin
            rand_all(55, 15);
            rec_ready = ($urandom_range(99) < 65);
            step();
        end
        drain();

        // Reset with four records buffered.
        rec_ready = 1'b0;
        repeat (2) begin rand_all(100, 0); step(); end
        chk("pre_reset_valid", 64'(rec_valid), 64'd1);
        do_reset();
        chk("post_reset_valid", 64'(rec_valid), 64'd0);
        chk("post_reset_instret", instret, 64'd0);
        chk("post_reset_state", 64'(state), 64'(RUN));

        // Directed tohost store on port 1 beside an ALU op on port 0.
        tohost    = TOHOST;
        rec_ready = 1'b1;
        drv[0] = rnd_instr(100, 0);
        drv[0].mem_wmask = '0;
        drv[1] = rnd_instr(100, 0);
        drv[1].mem_addr  = TOHOST;
        drv[1].mem_wdata = 64'h1;
        drv[1].mem_wmask = 8'hFF;
        step();
        chk("tohost_state", 64'(state), 64'(DONE));
        chk("tohost_exit_code", exit_code, 64'h1);
        chk("tohost_instret", instret, 64'd2);
        repeat (5) begin rand_all(100, 20); step(); end
        drain();

        // Random traffic with occasional tohost stores on either port.
        do_reset();
        tohost = TOHOST;
        repeat (150) begin
            rand_all(60, 15);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(99) < 4) begin
                    drv[i].valid     = 1'b1;
                    drv[i].mem_addr  = TOHOST;
                    drv[i].mem_wmask = 8'($urandom_range(255));
                    drv[i].mem_wdata = 64'($urandom_range(3));
                end
            end
            rec_ready = ($urandom_range(99) < 70);
            step();
        end
        drain();

        // Cycle limit without any tohost store.
        do_reset();
        tohost  = '0;
        timeout = 32'd100;
        repeat (110) begin
            rand_all(50, 10);
            rec_ready = ($urandom_range(99) < 70);
            step();
        end
        chk("timeout_state", 64'(state), 64'(TIMEOUT));
        chk("timeout_cycles", 64'(cycles), 64'd100);
        drain();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rvfi_commit_monitor.md
RVFI_COMMIT_MONITOR -- requirements
Module: rvfi_commit_monitor

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2: number of RVFI commit ports observed (1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: record buffer entries, power of 2, >= NR_COMMIT_PORTS.
REQ-003 SHALL have parameter HART_ID, default 8'h0: copied into every record.
REQ-004 SHALL have ports clk_i in 1 (single clock); rst_i in 1 (reset, synchronous, active-high).
REQ-005 SHALL have port rvfi_i in NR_COMMIT_PORTS x rvfi_pkg::rvfi_instr_t: commit stream, port 0 oldest.
REQ-006 SHALL have port tohost_addr_i in riscv::XLEN: termination address, 0 disables tohost detection.
REQ-007 SHALL have port timeout_i in 32: cycle limit, 0 disables timeout.
REQ-008 SHALL have ports rec_valid_o out 1, rec_ready_i in 1, rec_o out rvfi_monitor_pkg::trace_rec_t: record stream.
REQ-009 SHALL have ports state_o out rvfi_monitor_pkg::mon_state_e, exit_code_o out riscv::XLEN, exit_pc_o out 64.
REQ-010 SHALL have ports instret_o out 64, trap_cnt_o out 32, drop_cnt_o out 32, cycles_o out 32.

Function
REQ-011 SHALL treat port i as an event when rvfi_i[i].valid or rvfi_i[i].trap is 1 (valid takes precedence).
REQ-012 SHALL build a record per event: hart_id, port index, sign-extended 64-bit pc (bit VLEN-1 replicated), insn, mode, trap, cause, rd_addr, rd_wdata, mem_addr, mem_wdata, mem_wmask.
REQ-013 SHALL enqueue all events of one cycle in ascending port order, in that cycle, only in state RUN.
REQ-014 SHALL enqueue all-or-nothing: if event count > free entries (occupancy sampled before same-cycle pop), drop the whole batch and increment drop_cnt_o by the event count (saturating at 2^32-1).
REQ-015 SHALL pop one record per cycle when rec_valid_o && rec_ready_i; rec_o SHALL be stable while rec_valid_o && !rec_ready_i.
REQ-016 SHALL drive rec_valid_o from registered occupancy != 0; push-to-rec_valid_o latency 1 cycle on an empty buffer; no combinational path from rvfi_i to rec_*.
REQ-017 SHALL support simultaneous push and pop; full buffer with pop and 1 event SHALL still drop (conservative free count).
REQ-018 SHALL add the count of valid ports per cycle to instret_o (64-bit, wraps) and trap-only events to trap_cnt_o (saturating), only in RUN.
REQ-019 SHALL implement FSM RUN, DONE, TIMEOUT; reset state RUN.
REQ-020 RUN->DONE when some port is valid, mem_wmask != 0, mem_addr == tohost_addr_i, mem_wdata != 0, tohost_addr_i != 0; the lowest such port wins and exit_code_o/exit_pc_o capture its mem_wdata/pc.
REQ-021 The terminating instruction and lower ports of that cycle SHALL be enqueued and counted; higher ports of that cycle SHALL be ignored.
REQ-022 cycles_o SHALL increment every cycle in RUN; RUN->TIMEOUT when timeout_i != 0 and cycles_o == timeout_i; tohost hit in the same cycle SHALL win (DONE).
REQ-023 DONE and TIMEOUT SHALL be terminal until reset; counters frozen; buffer continues to drain via rec_ready_i.

Reset
REQ-024 On rst_i SHALL set state RUN, buffer empty, rec_valid_o 0, rec_o 0, all counters 0, exit_code_o 0, exit_pc_o 0.
REQ-025 Reset mid-operation SHALL discard buffered records without emitting them; rvfi_i is ignored during the reset cycle.

Structure
REQ-026 rvfi_monitor_pkg SHALL hold trace_rec_t, mon_state_e (RUN, DONE, TIMEOUT) and the cause-code constants 0..7.
REQ-027 Buffering SHALL be a sub-module rvfi_mw_fifo (multi-write single-read, parameters NR_WRITE, DEPTH, type) instantiated once.
REQ-028 Block SHALL be synthesizable: no DPI, file I/O or $finish; simulation-only reporting stays in the testbench.

Verification
REQ-029 Two ports valid every cycle for 3 cycles, rec_ready_i=1 -> 6 records in order p0,p1 per cycle, instret_o=6, drop_cnt_o=0.
REQ-030 FIFO_DEPTH=8, rec_ready_i=0, 2 events/cycle for 5 cycles -> occupancy 8, 5th batch dropped, drop_cnt_o=2, rec_o holds first record.
REQ-031 tohost_addr_i=0x8000_1000, port 1 SD wdata=0x1 to it, port 0 valid ALU op -> state DONE next cycle, exit_code_o=0x1, both records enqueued, later commits ignored.
REQ-032 timeout_i=100, no tohost store -> state TIMEOUT after cycle 100, cycles_o=100 frozen.
REQ-033 Port 0 trap=1 cause=2, valid=0 -> one record trap=1 cause=2, trap_cnt_o=1, instret_o unchanged.
REQ-034 rst_i asserted with 4 buffered records -> rec_valid_o=0 next cycle, counters 0, state RUN.
